// File: rtl/mtr_cmd_stage.sv
// Motor-command output stage: per-channel slew-limited command registers with a
// controlled ramp-down on drive loss, plus a hysteretic debounced battery-low flag.
module mtr_cmd_stage #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned W        = 11,
  parameter int unsigned STEP     = 64,
  parameter int unsigned RAMP_DIV = 4096,
  parameter int unsigned DEB_CYC  = 65536,
  parameter logic [11:0] LO_THR   = 12'h800,
  parameter logic [11:0] HI_THR   = 12'h880,
  parameter bit          fast_sim = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld,
  input  logic [NCH*W-1:0] spd_in,
  input  logic [NCH-1:0]   rev_in,
  input  logic             rider_off,
  input  logic             pwr_up,
  input  logic [11:0]      batt,
  output logic [NCH*W-1:0] spd_out,
  output logic [NCH-1:0]   rev_out,
  output logic             moving,
  output logic             batt_low
);

  localparam int unsigned RAMP_N = fast_sim ? 16 : RAMP_DIV;
  localparam int unsigned DEB_N  = fast_sim ? 8 : DEB_CYC;
  localparam int unsigned RW     = (RAMP_N > 1) ? $clog2(RAMP_N) : 1;
  localparam int unsigned DW     = $clog2(DEB_N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RAMP_DN} state_e;
  typedef logic signed [W:0] cur_t;

  localparam logic signed [W+1:0] STEP_D  = (W+2)'(STEP);
  localparam logic signed [W+1:0] NSTEP_D = -STEP_D;
  localparam cur_t                STEP_C  = (W+1)'(STEP);

  state_e           state_q, state_d;
  cur_t             cur_q [NCH];
  cur_t             cur_d [NCH];
  cur_t             tgt   [NCH];
  logic [RW-1:0]    ramp_cnt_q, ramp_cnt_d;
  logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
  logic             batt_low_q, batt_low_d;
  logic [NCH*W-1:0] spd_out_q, spd_out_d;
  logic [NCH-1:0]   rev_out_q, rev_out_d;
  logic             moving_q, moving_d;
  logic             all_zero;
  logic             batt_opp;
  cur_t             mag_ext;

  // One slew step: jump to tgt when within STEP, else move STEP toward it.
  // Difference is taken one bit wider than cur so +max to -max cannot wrap.
  function automatic cur_t slew_step(input cur_t cur, input cur_t tgt_v);
    logic signed [W+1:0] diff;
    diff = {tgt_v[W], tgt_v} - {cur[W], cur};
    if (diff > STEP_D)       slew_step = cur + STEP_C;
    else if (diff < NSTEP_D) slew_step = cur - STEP_C;
    else                     slew_step = tgt_v;
  endfunction

  function automatic logic [W-1:0] mag_of(input cur_t cur);
    cur_t pos;
    pos    = cur[W] ? -cur : cur;
    mag_of = pos[W-1:0];
  endfunction

  // Next-state, channel command and output computation.
  always_comb begin
    state_d    = state_q;
    ramp_cnt_d = ramp_cnt_q;
    all_zero   = 1'b1;
    mag_ext    = '0;
    for (int k = 0; k < NCH; k++) begin
      cur_d[k] = cur_q[k];
      mag_ext  = {1'b0, spd_in[k*W +: W]};
      tgt[k]   = rev_in[k] ? -mag_ext : mag_ext;
      if (cur_q[k] != '0) all_zero = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        for (int k = 0; k < NCH; k++) cur_d[k] = '0;
        if (pwr_up && !rider_off) state_d = S_RUN;
      end
      S_RUN: begin
        // Drive loss wins over a coincident command strobe.
        if (!pwr_up || rider_off) begin
          state_d    = S_RAMP_DN;
          ramp_cnt_d = '0;
        end else if (vld) begin
          for (int k = 0; k < NCH; k++) cur_d[k] = slew_step(cur_q[k], tgt[k]);
        end
      end
      S_RAMP_DN: begin
        if (all_zero) begin
          state_d    = S_IDLE;
          ramp_cnt_d = '0;
        end else if (ramp_cnt_q == RW'(RAMP_N - 1)) begin
          ramp_cnt_d = '0;
          for (int k = 0; k < NCH; k++) cur_d[k] = slew_step(cur_q[k], '0);
        end else begin
          ramp_cnt_d = ramp_cnt_q + RW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    moving_d = (state_d == S_RUN);
    for (int k = 0; k < NCH; k++) begin
      rev_out_d[k]         = cur_d[k][W];
      spd_out_d[k*W +: W]  = mag_of(cur_d[k]);
    end
  end

  // Battery-low debounce: count consecutive cycles arguing against the flag.
  always_comb begin
    batt_low_d = batt_low_q;
    deb_cnt_d  = '0;
    batt_opp   = batt_low_q ? (batt >= HI_THR) : (batt < LO_THR);
    if (batt_opp) begin
      if (deb_cnt_q == DW'(DEB_N - 1)) begin
        batt_low_d = ~batt_low_q;
        deb_cnt_d  = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ramp_cnt_q <= '0;
      deb_cnt_q  <= '0;
      batt_low_q <= 1'b0;
      spd_out_q  <= '0;
      rev_out_q  <= '0;
      moving_q   <= 1'b0;
      for (int k = 0; k < NCH; k++) cur_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      ramp_cnt_q <= ramp_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      batt_low_q <= batt_low_d;
      spd_out_q  <= spd_out_d;
      rev_out_q  <= rev_out_d;
      moving_q   <= moving_d;
      for (int k = 0; k < NCH; k++) cur_q[k] <= cur_d[k];
    end
  end

  assign spd_out  = spd_out_q;
  assign rev_out  = rev_out_q;
  assign moving   = moving_q;
  assign batt_low = batt_low_q;

endmodule

// File: tb/tb_mtr_cmd_stage.sv
// Directed self-checking bench for mtr_cmd_stage (NCH=2, W=11, STEP=64, fast_sim=1).
module tb_mtr_cmd_stage;

  localparam int unsigned NCH = 2;
  localparam int unsigned W   = 11;

  logic             clk;
  logic             rst_n;
  logic             vld;
  logic [NCH*W-1:0] spd_in;
  logic [NCH-1:0]   rev_in;
  logic             rider_off;
  logic             pwr_up;
  logic [11:0]      batt;
  logic [NCH*W-1:0] spd_out;
  logic [NCH-1:0]   rev_out;
  logic             moving;
  logic             batt_low;

  int n_chk;
  int n_fail;

  mtr_cmd_stage #(
    .NCH(NCH), .W(W), .STEP(64), .RAMP_DIV(4096), .DEB_CYC(65536),
    .LO_THR(12'h800), .HI_THR(12'h880), .fast_sim(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .spd_in(spd_in), .rev_in(rev_in),
    .rider_off(rider_off), .pwr_up(pwr_up), .batt(batt),
    .spd_out(spd_out), .rev_out(rev_out), .moving(moving), .batt_low(batt_low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_cmd(input int s0, input bit r0, input int s1, input bit r1);
    spd_in[0 +: W] = W'(s0);
    spd_in[W +: W] = W'(s1);
    rev_in         = {r1, r0};
  endtask

  task automatic pulse_vld;
    vld = 1'b1;
    tick();
    vld = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; vld = 1'b0; spd_in = '0; rev_in = '0;
    rider_off = 1'b0; pwr_up = 1'b0; batt = 12'h900;
    tick(2);
    chk("rst_spd", spd_out, 0);
    chk("rst_rev", rev_out, 0);
    chk("rst_moving", moving, 0);
    chk("rst_batt_low", batt_low, 0);
    rst_n = 1'b1;
    tick();

    // IDLE ignores commands, then RUN accepts them
    set_cmd(500, 0, 0, 0);
    pulse_vld();
    tick();
    chk("idle_spd", spd_out, 0);
    chk("idle_moving", moving, 0);
    pwr_up = 1'b1;
    tick();
    chk("run_moving", moving, 1);
    pulse_vld();
    chk("run_first_step", spd_out[0 +: W], 64);
    set_cmd(0, 0, 0, 0);
    pulse_vld();
    chk("run_back_zero", spd_out[0 +: W], 0);

    // Forward slew to 200, ch1 small reverse jump in one step
    set_cmd(200, 0, 50, 1);
    pulse_vld();
    chk("fwd_ch0_1", spd_out[0 +: W], 64);
    chk("fwd_ch1", spd_out[W +: W], 50);
    chk("fwd_rev_1", rev_out, 2'b10);
    pulse_vld();
    chk("fwd_ch0_2", spd_out[0 +: W], 128);
    pulse_vld();
    chk("fwd_ch0_3", spd_out[0 +: W], 192);
    pulse_vld();
    chk("fwd_ch0_4", spd_out[0 +: W], 200);
    chk("fwd_rev_4", rev_out, 2'b10);

    // Bring ch0 to +100, then reverse through zero
    set_cmd(100, 0, 50, 1);
    pulse_vld();
    chk("dn_136", spd_out[0 +: W], 136);
    pulse_vld();
    chk("dn_100", spd_out[0 +: W], 100);
    set_cmd(100, 1, 50, 1);
    pulse_vld();
    chk("revx_spd_1", spd_out[0 +: W], 36);
    chk("revx_dir_1", rev_out[0], 0);
    pulse_vld();
    chk("revx_spd_2", spd_out[0 +: W], 28);
    chk("revx_dir_2", rev_out[0], 1);
    pulse_vld();
    chk("revx_spd_3", spd_out[0 +: W], 92);
    chk("revx_dir_3", rev_out[0], 1);
    pulse_vld();
    chk("revx_spd_4", spd_out[0 +: W], 100);
    chk("revx_dir_4", rev_out[0], 1);

    // -100 -> +300 on ch0, ch1 back to 0
    set_cmd(300, 0, 0, 0);
    pulse_vld();
    chk("to300_first", spd_out[0 +: W], 36);
    chk("to300_ch1", spd_out[W +: W], 0);
    chk("to300_rev", rev_out, 2'b01);
    for (int i = 0; i < 6; i++) pulse_vld();
    chk("to300_final", spd_out[0 +: W], 300);
    chk("to300_rev_final", rev_out, 0);

    // Rider leaves with a coincident command: command dropped, ramp-down follows
    set_cmd(500, 0, 0, 0);
    rider_off = 1'b1;
    pulse_vld();
    chk("exit_vld_dropped", spd_out[0 +: W], 300);
    chk("exit_moving", moving, 0);
    tick(15);
    chk("ramp_hold", spd_out[0 +: W], 300);
    tick();
    chk("ramp_236", spd_out[0 +: W], 236);
    rider_off = 1'b0;
    tick(16);
    chk("ramp_172", spd_out[0 +: W], 172);
    chk("ramp_no_rerun", moving, 0);
    tick(16);
    chk("ramp_108", spd_out[0 +: W], 108);
    tick(16);
    chk("ramp_44", spd_out[0 +: W], 44);
    tick(16);
    chk("ramp_0", spd_out[0 +: W], 0);
    chk("ramp_0_moving", moving, 0);
    tick();
    chk("ramp_idle_moving", moving, 0);
    tick();
    chk("rerun_moving", moving, 1);

    // Mid-ramp asynchronous reset
    set_cmd(200, 0, 0, 0);
    pulse_vld();
    pulse_vld();
    chk("pre_ramp_128", spd_out[0 +: W], 128);
    pwr_up = 1'b0;
    tick(5);
    chk("mid_ramp_hold", spd_out[0 +: W], 128);
    rst_n = 1'b0;
    #1;
    chk("async_rst_spd", spd_out, 0);
    chk("async_rst_moving", moving, 0);
    tick();
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_idle", moving, 0);
    chk("post_rst_spd", spd_out, 0);

    // Battery-low debounce and hysteresis
    batt = 12'h7FF;
    tick(7);
    chk("batt_7_low", batt_low, 0);
    batt = 12'h900;
    tick();
    chk("batt_broken", batt_low, 0);
    batt = 12'h800;
    tick(10);
    chk("batt_at_lo_thr", batt_low, 0);
    batt = 12'h7FF;
    tick(7);
    chk("batt_7_again", batt_low, 0);
    tick();
    chk("batt_set", batt_low, 1);
    batt = 12'h820;
    tick(10);
    chk("batt_hyst_hold", batt_low, 1);
    batt = 12'h880;
    tick(7);
    chk("batt_clr_7", batt_low, 1);
    tick();
    chk("batt_clr", batt_low, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
